// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional per-grant header frame (8'hA0 | requester index) when UART_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_val,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
`ifdef UART_ARB_HEADER_EN
    S_HDR,
`endif
    S_WAIT_DONE
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IDX_W-1:0]   gidx, gidx_n, ptr, ptr_n, pick, cand;
  logic [7:0]         burst_cnt, burst_n, tx_val_n, sel_data;
  logic               last_flag, last_n, tx_start_n, found;
`ifdef UART_ARB_HEADER_EN
  logic               hdr_flag, hdr_n;
`endif

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  assign sel_data  = req_data[{gidx, 3'b000} +: 8];
  assign req_ready = (state == S_SEND && tx_done) ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      last_flag <= 1'b0;
      tx_val    <= '0;
      tx_start  <= 1'b0;
`ifdef UART_ARB_HEADER_EN
      hdr_flag  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      gidx      <= gidx_n;
      ptr       <= ptr_n;
      burst_cnt <= burst_n;
      last_flag <= last_n;
      tx_val    <= tx_val_n;
      tx_start  <= tx_start_n;
`ifdef UART_ARB_HEADER_EN
      hdr_flag  <= hdr_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    gidx_n     = gidx;
    ptr_n      = ptr;
    burst_n    = burst_cnt;
    last_n     = last_flag;
    tx_val_n   = tx_val;
    tx_start_n = 1'b0;
    found      = 1'b0;
    pick       = '0;
    cand       = '0;
`ifdef UART_ARB_HEADER_EN
    hdr_n      = hdr_flag;
`endif
    // First valid requester at or after the pointer, wrapping.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(ptr, i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          gidx_n        = pick;
          burst_n       = '0;
`ifdef UART_ARB_HEADER_EN
          state_n       = S_HDR;
`else
          state_n       = S_SEND;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        if (tx_done) begin
          tx_val_n   = 8'hA0 | 8'(gidx);
          tx_start_n = 1'b1;
          hdr_n      = 1'b1;
          state_n    = S_WAIT_ACK;
        end
      end
`endif
      S_SEND: begin
        if (tx_done && req_valid[gidx]) begin
          tx_val_n   = sel_data;
          tx_start_n = 1'b1;
          last_n     = req_last[gidx] | (burst_cnt == 8'(MAX_BURST - 1));
          burst_n    = burst_cnt + 8'd1;
          state_n    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!tx_done) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
`ifdef UART_ARB_HEADER_EN
          if (hdr_flag) begin
            hdr_n   = 1'b0;
            state_n = S_SEND;
          end else
`endif
          if (last_flag) begin
            ptr_n   = wrap_idx(gidx, 1);
            grant_n = '0;
            state_n = S_IDLE;
          end else begin
            state_n = S_SEND;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: byte-source queues, transmitter done model, frame monitor.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
`ifdef UART_ARB_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_val;
  logic                 tx_start;
  logic                 tx_done = 1'b1;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_val(tx_val),
    .tx_start(tx_start), .tx_done(tx_done), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] g; logic [7:0] v; logic ok; } frame_t;
  typedef logic [8:0] ent_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  ent_t   src_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] acc = '0;
  logic   pend = 1'b0;
  int     done_cnt = 0;
  int     vectors = 0;
  int     miscompares = 0;

  // Sources, transmitter model and frame monitor, all stepped on the falling edge.
  always begin
    ent_t h;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (tx_start) obs_q.push_back(frame_t'{g: grant, v: tx_val, ok: tx_done});
    if (pend) begin
      tx_done = 1'b0; done_cnt = 20; pend = 1'b0;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start) pend = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    #1;
    acc = req_valid & req_ready & {NUM_REQ{~rst}};
  end

  task automatic exp_frame(input int g, input logic [7:0] v);
    exp_q.push_back(frame_t'{g: 4'(1 << g), v: v, ok: 1'b1});
  endtask

  task automatic exp_hdr(input int g);
`ifdef UART_ARB_HEADER_EN
    exp_q.push_back(frame_t'{g: 4'(1 << g), v: 8'hA0 | 8'(g), ok: 1'b1});
`else
    if (g < 0) $display("unreachable %0d", g);
`endif
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < 3000) begin @(negedge clk); c++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < 500) begin @(negedge clk); c++; end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("FAIL reset_grant got %b need 0000", grant); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b need 0", tx_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b need 0", busy); end
    vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready got %b need 0000", req_ready); end
    vectors++; if (tx_val !== 8'h00) begin miscompares++; $display("FAIL reset_txval got %h need 00", tx_val); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok; frame_t f, e;
    src_q[0].push_back({1'b0, 8'h55});
    src_q[0].push_back({1'b1, 8'h12});
    exp_hdr(0); exp_frame(0, 8'h55); exp_frame(0, 8'h12);
    wait_frames(2 + H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout got %0d frames need %0d", obs_q.size(), 2 + H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL single_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    wait_idle(ok);
    repeat (3) @(negedge clk);
    vectors++; if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b need 0", busy); end
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("FAIL single_grant got %b need 0000", grant); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL single_extra_starts got %0d need 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_contention();
    bit ok; frame_t f, e;
    @(negedge clk);
    src_q[1].push_back({1'b0, 8'h1A}); src_q[1].push_back({1'b1, 8'h1B});
    src_q[3].push_back({1'b0, 8'h3A}); src_q[3].push_back({1'b1, 8'h3B});
    exp_hdr(1); exp_frame(1, 8'h1A); exp_frame(1, 8'h1B);
    exp_hdr(3); exp_frame(3, 8'h3A); exp_frame(3, 8'h3B);
    wait_frames(4 + 2*H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL contention_timeout got %0d frames need %0d", obs_q.size(), 4 + 2*H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL contention_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    wait_idle(ok);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_round_robin();
    bit ok; frame_t f, e;
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) begin
        src_q[i].push_back({1'b1, 8'(8'h40 + 16*r + i)});
        exp_hdr(i); exp_frame(i, 8'(8'h40 + 16*r + i));
      end
    wait_frames(8 + 8*H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_timeout got %0d frames need %0d", obs_q.size(), 8 + 8*H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL rr_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    wait_idle(ok);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_burst_cap();
    bit ok; int c; frame_t f, e;
    @(negedge clk);
    for (int b = 1; b <= 6; b++) src_q[2].push_back({b == 6, 8'(8'h20 + b)});
    c = 0;
    while (grant !== 4'b0100 && c < 100) begin @(negedge clk); c++; end
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL burst_grant got %b need 0100", grant); end
    src_q[0].push_back({1'b1, 8'h01});
    exp_hdr(2);
    for (int b = 1; b <= 4; b++) exp_frame(2, 8'(8'h20 + b));
    exp_hdr(0); exp_frame(0, 8'h01);
    exp_hdr(2); exp_frame(2, 8'h25); exp_frame(2, 8'h26);
    wait_frames(7 + 3*H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL burst_timeout got %0d frames need %0d", obs_q.size(), 7 + 3*H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL burst_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    wait_idle(ok);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall_reset();
    bit ok, held; frame_t f, e;
    @(negedge clk);
    src_q[0].push_back({1'b0, 8'h31});
    exp_hdr(0); exp_frame(0, 8'h31);
    wait_frames(1 + H, ok);
    repeat (25) @(negedge clk);
    held = 1'b1;
    repeat (50) begin @(negedge clk); if (grant !== 4'b0001 || tx_start !== 1'b0) held = 1'b0; end
    vectors++; if (!held) begin miscompares++; $display("FAIL stall_hold got grant=%b start=%b need grant=0001 start=0", grant, tx_start); end
    src_q[0].push_back({1'b0, 8'h32});
    exp_frame(0, 8'h32);
    wait_frames(2 + H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout got %0d frames need %0d", obs_q.size(), 2 + H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL stall_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b1 || tx_done !== 1'b0) begin miscompares++; $display("FAIL midframe_busy got busy=%b done=%b need 1 0", busy, tx_done); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (grant !== 4'b0) begin miscompares++; $display("FAIL rst_grant got %b need 0000", grant); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_start got %b need 0", tx_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b need 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete(); obs_q.delete();
    repeat (2) @(negedge clk);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rst_no_start got %0d frames need 0", obs_q.size()); end
    // A cleared pointer favours req0 over req3.
    src_q[3].push_back({1'b1, 8'h73});
    src_q[0].push_back({1'b1, 8'h03});
    exp_hdr(0); exp_frame(0, 8'h03); exp_hdr(3); exp_frame(3, 8'h73);
    wait_frames(2 + 2*H, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ptr_timeout got %0d frames need %0d", obs_q.size(), 2 + 2*H); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (f !== e) begin miscompares++; $display("FAIL ptr_frame got g=%b v=%h ok=%b need g=%b v=%h ok=%b", f.g, f.v, f.ok, e.g, e.v, e.ok); end
    end
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL final_idle got busy=%b need 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_burst_cap();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
